serial_adder: RTL

- Bit-serial adder built around one `full_adder` cell plus a carry flip-flop; adds two WIDTH-bit operands LSB-first, one bit per clock.
- Sits directly upstream of the ALU result path. It is the sequential, area-minimal alternative to the ripple chain of `full_adder` instances.
- Operands and result move over a simple start/busy/done handshake.

---
 rtl/serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder cell plus a carry FF; optional subtract via SERIAL_ADDER_SUB_EN.
// Latency: done pulses in the cycle after edge E0+WIDTH (start sampled at E0); one add per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, and accepted again in IDLE or in the DONE cycle.

module full_adder (
    input  logic z,
    input  logic l,
    input  logic m,
    output logic s,
    output logic c
);
    assign s = z ^ l ^ m;
    assign c = (z & l) | (z & m) | (l & m);
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] next_res;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    full_adder u_fa (
        .z (sa[0]),
        .l (sb[0]),
        .m (carry),
        .s (fa_s),
        .c (fa_c)
    );

    // The newest sum bit enters at the MSB; on the last shift next_res is the full result.
    assign next_res = {fa_s, res};

    // Subtraction is a + ~b + 1, so only the B operand and initial carry change.
    always_comb begin
        load_b = b;
        load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            load_b = ~b;
            load_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= load_b;
                        carry <= load_c;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= next_res[WIDTH-1:1];
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= next_res;
                        cout  <= fa_c;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
